// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/decoder and ahb_sram_slave.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte lanes, programmable
// wait states, two-cycle ERROR response and write-to-read forwarding.
module ahb_sram_slave #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned AQ_W       = IDX_W + 2;
    localparam logic [18:0] ADDR_LIMIT = 19'(MEM_WORDS * 4);
    localparam logic [2:0]  WS_LOAD    = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AQ_W-1:0]   addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic              hreadyout_q, hreadyout_d;
    logic [1:0]        hresp_q, hresp_d;

    logic [31:0]       mem_q [MEM_WORDS];

    logic              accept;
    logic              req_err;
    logic              wr_commit;
    logic [IDX_W-1:0]  wr_idx;
    logic [3:0]        wr_be;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_write;
    logic [31:0]       rd_word;

    logic              unused_bits;
    assign unused_bits = ^{bus.HADDR[31:18], bus.HTRANS[0]};

    // Byte lanes touched by a transfer of the given size at the given offset.
    function automatic logic [3:0] lane_mask(logic [2:0] size, logic [1:0] off);
        case (size)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Address-phase decode: acceptance and error classification.
    always_comb begin
        accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1]
                  && (state_q inside {S_IDLE, S_LAST, S_ERR2});
        req_err = (bus.HSIZE > 3'b010)
                  || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
                  || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00))
                  || ({1'b0, bus.HADDR[17:0]} >= ADDR_LIMIT);
    end

    // Next-state, wait counter, address-phase latches and registered responses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_IDLE, S_LAST, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = bus.HADDR[AQ_W-1:0];
                    write_d = bus.HWRITE;
                    size_d  = bus.HSIZE;
                    if (req_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_LAST;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_LAST;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        hreadyout_d = !(state_d inside {S_WAIT, S_ERR1});
        hresp_d     = (state_d inside {S_ERR1, S_ERR2}) ? 2'b01 : 2'b00;
    end

    // Data path: write commit at the end of LAST, read load on entry to LAST
    // with same-edge forwarding of the committing write.
    always_comb begin
        wr_commit = (state_q == S_LAST) && write_q && !HRESET;
        wr_idx    = addr_q[2 +: IDX_W];
        wr_be     = lane_mask(size_q, addr_q[1:0]);
        rd_idx    = accept ? bus.HADDR[2 +: IDX_W] : addr_q[2 +: IDX_W];
        rd_write  = accept ? bus.HWRITE : write_q;
        rd_word   = mem_q[rd_idx];
        if (wr_commit && (wr_idx == rd_idx)) begin
            for (int n = 0; n < 4; n++) begin
                if (wr_be[n]) begin
                    rd_word[8*n +: 8] = bus.HWDATA[8*n +: 8];
                end
            end
        end
        hrdata_d = hrdata_q;
        if ((state_d == S_LAST) && !rd_write) begin
            hrdata_d = rd_word;
        end
    end

    // Control and response registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            hrdata_q    <= 32'h0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int n = 0; n < 4; n++) begin
                if (wr_be[n]) begin
                    mem_q[wr_idx][8*n +: 8] <= bus.HWDATA[8*n +: 8];
                end
            end
        end
    end

    assign bus.HRDATA    = hrdata_q;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed/randomised bench for ahb_sram_slave: one zero-wait and one
// single-wait instance, driven by a pipelined AHB master with a scoreboard.
module tb_ahb_sram_slave;
    localparam int unsigned MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          sel;
    int          checks;
    int          errors;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus1 ();

    assign bus0.HSEL   = hsel && (sel == 0);
    assign bus0.HADDR  = haddr;
    assign bus0.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;

    assign bus1.HSEL   = hsel && (sel == 1);
    assign bus1.HADDR  = haddr;
    assign bus1.HTRANS = htrans;
    assign bus1.HWRITE = hwrite;
    assign bus1.HSIZE  = hsize;
    assign bus1.HWDATA = hwdata;
    assign bus1.HREADY = bus1.HREADYOUT;

    ahb_sram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(0)) u_dut0 (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus0)
    );

    ahb_sram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(1)) u_dut1 (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
    } xfer_t;

    typedef struct {
        logic        err;
        logic [31:0] wd;
        logic [31:0] hr;
    } exp_t;

    xfer_t       txq[$];
    exp_t        sbq[$];
    logic [31:0] mdl [int];
    logic [31:0] exp_hr [2];

    function automatic logic [31:0] cur_rdata();
        return (sel == 1) ? bus1.HRDATA : bus0.HRDATA;
    endfunction

    function automatic logic cur_ready();
        return (sel == 1) ? bus1.HREADYOUT : bus0.HREADYOUT;
    endfunction

    function automatic logic [1:0] cur_resp();
        return (sel == 1) ? bus1.HRESP : bus0.HRESP;
    endfunction

    function automatic logic is_err(logic [31:0] a, logic [2:0] sz);
        return (sz > 3'd2) || ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00))
               || (a[17:0] >= 18'(MEM_WORDS * 4));
    endfunction

    function automatic void model_write(int s, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        int          key;
        logic [31:0] w;
        logic        en;
        key = s * 65536 + int'(a[17:2]);
        w   = mdl.exists(key) ? mdl[key] : 32'h0;
        for (int n = 0; n < 4; n++) begin
            en = (sz == 3'd2) || ((sz == 3'd1) && ((n / 2) == int'(a[1])))
                 || ((sz == 3'd0) && (n == int'(a[1:0])));
            if (en) w[8*n +: 8] = wd[8*n +: 8];
        end
        mdl[key] = w;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add(logic w, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        xfer_t t;
        t.w  = w;
        t.a  = a;
        t.sz = sz;
        t.wd = wd;
        txq.push_back(t);
    endtask

    // Record an accepted transfer: update the reference memory and queue the
    // HRDATA value expected when its data phase completes.
    task automatic push_exp(xfer_t t);
        exp_t e;
        e.err = is_err(t.a, t.sz);
        e.wd  = t.wd;
        if (!e.err && t.w) model_write(sel, t.a, t.sz, t.wd);
        if (!e.err && !t.w) exp_hr[sel] = mdl[sel * 65536 + int'(t.a[17:2])];
        e.hr = exp_hr[sel];
        sbq.push_back(e);
    endtask

    // Pipelined master: issues queued transfers back to back and checks
    // every cycle's HREADYOUT/HRESP plus HRDATA at each data-phase end.
    task automatic run_q(string tag);
        int          ai;
        int          k;
        int          guard;
        int          ws;
        logic        ro;
        logic [1:0]  rp;
        logic [31:0] rd;
        ai    = 0;
        k     = 0;
        guard = 0;
        ws    = (sel == 1) ? 1 : 0;
        while (((ai < txq.size()) || (sbq.size() > 0)) && (guard < 400)) begin
            guard++;
            if (ai < txq.size()) begin
                hsel = 1'b1; htrans = 2'b10; haddr = txq[ai].a;
                hwrite = txq[ai].w; hsize = txq[ai].sz;
            end else begin
                hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
            end
            hwdata = (sbq.size() > 0) ? sbq[0].wd : 32'h0;
            @(negedge clk);
            ro = cur_ready();
            rp = cur_resp();
            rd = cur_rdata();
            if (sbq.size() > 0) begin
                k++;
                chk({tag, "_ready"}, 32'(ro), 32'(sbq[0].err ? (k == 2) : (k == ws + 1)));
                chk({tag, "_resp"}, 32'(rp), sbq[0].err ? 32'd1 : 32'd0);
                if (ro) begin
                    chk({tag, "_rdata"}, rd, sbq[0].hr);
                    void'(sbq.pop_front());
                    k = 0;
                end else if (k > 3) begin
                    checks++;
                    errors++;
                    $error("FAIL %s_stall observed=no_ready expected=ready_within_2", tag);
                    sbq.delete();
                    txq.delete();
                end
            end else begin
                chk({tag, "_idle_ready"}, 32'(ro), 32'd1);
                chk({tag, "_idle_resp"}, 32'(rp), 32'd0);
            end
            @(posedge clk);
            #1;
            if (ro && (ai < txq.size())) begin
                push_exp(txq[ai]);
                ai++;
            end
        end
        if (guard >= 400) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=busy expected=drained", tag);
        end
        txq.delete();
        sbq.delete();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        checks = 0;
        errors = 0;
        sel    = 1;
        rst    = 1'b1;
        hsel   = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0;
        exp_hr[0] = 32'h0;
        exp_hr[1] = 32'h0;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready1", 32'(bus1.HREADYOUT), 32'd1);
        chk("reset_resp1", 32'(bus1.HRESP), 32'd0);
        chk("reset_rdata1", bus1.HRDATA, 32'h0);
        chk("reset_ready0", 32'(bus0.HREADYOUT), 32'd1);
        chk("reset_rdata0", bus0.HRDATA, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Word write then read with one wait state.
        sel = 1;
        add(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        add(1'b0, 32'h10, 3'd2, 32'h0);
        run_q("word_rw");
        chk("word_rw_const", cur_rdata(), 32'hDEADBEEF);

        // Byte-lane merging.
        add(1'b1, 32'h20, 3'd2, 32'h11223344);
        add(1'b1, 32'h22, 3'd0, 32'h00AA0000);
        add(1'b1, 32'h20, 3'd1, 32'h00005566);
        add(1'b0, 32'h20, 3'd2, 32'h0);
        run_q("lanes");
        chk("lanes_const", cur_rdata(), 32'h11AA5566);

        // Error transfers leave memory and HRDATA untouched.
        add(1'b0, 32'h2, 3'd2, 32'h0);
        add(1'b0, 32'h1000, 3'd2, 32'h0);
        add(1'b1, 32'h1010, 3'd2, 32'hFFFFFFFF);
        add(1'b1, 32'h21, 3'd1, 32'hFFFFFFFF);
        add(1'b0, 32'h20, 3'd3, 32'h0);
        run_q("errors");
        chk("errors_hold", cur_rdata(), 32'h11AA5566);
        add(1'b0, 32'h10, 3'd2, 32'h0);
        add(1'b0, 32'h20, 3'd2, 32'h0);
        run_q("after_err");
        chk("after_err_const", cur_rdata(), 32'h11AA5566);

        // IDLE and BUSY selected: zero-wait OKAY, no memory access.
        hsel = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20; hwdata = 32'hFFFFFFFF;
        htrans = 2'b00;
        @(negedge clk);
        chk("idle_ready", 32'(bus1.HREADYOUT), 32'd1);
        chk("idle_resp", 32'(bus1.HRESP), 32'd0);
        @(posedge clk);
        #1 htrans = 2'b01;
        @(negedge clk);
        chk("busy_ready", 32'(bus1.HREADYOUT), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_after_ready", 32'(bus1.HREADYOUT), 32'd1);
        chk("busy_after_resp", 32'(bus1.HRESP), 32'd0);
        @(posedge clk);
        #1 hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
        add(1'b0, 32'h20, 3'd2, 32'h0);
        run_q("idle_busy");
        chk("idle_busy_const", cur_rdata(), 32'h11AA5566);

        // Zero-wait instance: write-to-read forwarding, full word and byte.
        sel = 0;
        add(1'b1, 32'h40, 3'd2, 32'hCAFEF00D);
        add(1'b0, 32'h40, 3'd2, 32'h0);
        run_q("fwd");
        chk("fwd_const", cur_rdata(), 32'hCAFEF00D);
        add(1'b1, 32'h41, 3'd0, 32'h00005A00);
        add(1'b0, 32'h40, 3'd2, 32'h0);
        run_q("fwd_byte");
        chk("fwd_byte_const", cur_rdata(), 32'hCAFE5A0D);

        // Back-to-back random traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 16; i++) add(1'b1, 32'h100 + 32'(4 * i), 3'd2, $urandom);
            for (int i = 0; i < 24; i++) begin
                sz = 3'($urandom_range(0, 2));
                a  = 32'h100 + 32'(4 * $urandom_range(0, 15));
                if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
                if (sz == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) a = a + 32'h2000;
                add(1'($urandom_range(0, 1)), a, sz, $urandom);
            end
            run_q((s == 0) ? "burst0" : "burst1");
        end

        // Reset during WAIT of a write abandons it.
        sel = 1;
        add(1'b1, 32'h80, 3'd2, 32'h0BADF00D);
        add(1'b0, 32'h10, 3'd2, 32'h0);
        run_q("pre80");
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h80; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        chk("rst_acc_ready", 32'(bus1.HREADYOUT), 32'd1);
        @(posedge clk);
        #1 hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h12345678;
        @(negedge clk);
        chk("rst_wait_ready", 32'(bus1.HREADYOUT), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_now_ready", 32'(bus1.HREADYOUT), 32'd1);
        chk("rst_now_resp", 32'(bus1.HRESP), 32'd0);
        chk("rst_now_rdata1", bus1.HRDATA, 32'h0);
        chk("rst_now_rdata0", bus0.HRDATA, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        hwdata = 32'h0;
        exp_hr[0] = 32'h0;
        exp_hr[1] = 32'h0;
        add(1'b0, 32'h80, 3'd2, 32'h0);
        run_q("post_rst");
        chk("post_rst_const", cur_rdata(), 32'h0BADF00D);
        sel = 0;
        add(1'b0, 32'h40, 3'd2, 32'h0);
        run_q("post_rst0");
        chk("post_rst0_const", cur_rdata(), 32'hCAFE5A0D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameters SHALL be as follows, one per line:
  MEM_WORDS, 1024, number of 32-bit words of storage; range 1..65536.
  WAIT_STATES, 1, number of HREADYOUT-low cycles inserted per OKAY transfer; range 0..7.
REQ-002 Ports SHALL be as follows, one per line:
  HCLK  in  1  single clock; all state changes on its rising edge.
  HRESET  in  1  asynchronous, active-high reset.
  HSEL  in  1  slave select from the address decoder.
  HADDR  in  32  transfer address.
  HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
  HWRITE  in  1  1 = write, 0 = read.
  HSIZE  in  3  transfer size: 000 byte, 001 half, 010 word.
  HWDATA  in  32  write data, valid during the data phase.
  HREADY  in  1  bus-level ready (HREADYIN).
  HRDATA  out  32  read data.
  HREADYOUT  out  1  slave ready.
  HRESP  out  2  response: 00 OKAY, 01 ERROR.

Function
REQ-003 An address phase SHALL be accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE SHALL be latched on that edge.
REQ-004 HSEL=1 with IDLE or BUSY SHALL get a zero-wait OKAY response with no memory access.
REQ-005 An accepted transfer SHALL be classed as an error if HSIZE>010, HSIZE=001 with HADDR[0]=1, HSIZE=010 with HADDR[1:0]!=00, or HADDR[17:0] >= MEM_WORDS*4.
REQ-006 The FSM SHALL have the states IDLE, WAIT, LAST, ERR1 and ERR2.
REQ-007 Transitions from IDLE on accept SHALL be: error -> ERR1; WAIT_STATES>0 -> WAIT (counter loaded with WAIT_STATES-1); WAIT_STATES=0 -> LAST.
REQ-008 WAIT SHALL drive HREADYOUT=0 and HRESP=00, decrement the counter each cycle, and go to LAST when the counter is 0.
REQ-009 LAST SHALL drive HREADYOUT=1 and HRESP=00 and perform the data phase; a new accept in LAST SHALL follow REQ-007, otherwise the next state is IDLE.
REQ-010 ERR1 SHALL drive HREADYOUT=0 and HRESP=01, then go to ERR2.
REQ-011 ERR2 SHALL drive HREADYOUT=1 and HRESP=01; a new accept in ERR2 SHALL follow REQ-007, otherwise the next state is IDLE.
REQ-012 Error transfers SHALL neither write memory nor update HRDATA.
REQ-013 Writes SHALL commit on the rising edge ending LAST, using little-endian byte lanes: byte n = HWDATA[8n+7:8n]; only the lanes selected by the latched HSIZE and HADDR[1:0] change.
REQ-014 HRDATA SHALL be a register loaded on the edge entering LAST, with the full word at index HADDR[17:2].
REQ-015 HRDATA SHALL hold its value in all other states.
REQ-016 If a write commits on the same edge that loads HRDATA for a read of the same word, HRDATA SHALL return the merged new data (write-to-read forwarding).
REQ-017 Back-to-back pipelined transfers SHALL sustain one transfer per (WAIT_STATES+1) cycles with no idle cycle between them.
REQ-018 While HREADYOUT=0 the block SHALL ignore HSEL, HTRANS and HADDR, since HREADY is low.

Reset
REQ-019 Asserting HRESET SHALL immediately force: state IDLE, counter 0, HREADYOUT=1, HRESP=00, HRDATA=32'h0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 A reset during WAIT, LAST or ERR1 SHALL abandon the transfer, and no write SHALL commit on or after the reset assertion.
REQ-022 The first accept SHALL be possible on the first rising edge after HRESET deasserts.

Verification
REQ-023 Word write then read, WAIT_STATES=1: write 32'hDEADBEEF to 0x0000_0010, then read 0x10 -> each transfer has 1 cycle HREADYOUT=0; HRDATA=32'hDEADBEEF with HRESP=00.
REQ-024 Byte lanes: word 0x11223344 at 0x20, then byte write 0xAA at 0x22 (HWDATA=32'h00AA0000), then halfword write 0x5566 at 0x20 -> reading 0x20 gives 32'h11AA5566.
REQ-025 Errors: word read at 0x0000_0002 and word read at 0x0000_1000 (MEM_WORDS=1024) -> for each, one cycle HREADYOUT=0/HRESP=01 then one cycle HREADYOUT=1/HRESP=01; memory and HRDATA unchanged.
REQ-026 Forwarding, WAIT_STATES=0: write 32'hCAFEF00D to 0x40 immediately followed by a read of 0x40 -> the read returns 32'hCAFEF00D with zero wait.
REQ-027 Reset mid-transfer: assert HRESET during WAIT of a write of 32'h12345678 to 0x80 -> HREADYOUT=1 and HRDATA=0 immediately; a later read of 0x80 returns the pre-write value.
REQ-028 IDLE/BUSY handling: HSEL=1 with HTRANS=00 and then 01 -> HREADYOUT=1, HRESP=00, no memory change.
